// File: rtl/bn_stream_mux_rr.sv
// N:1 valid/ready stream multiplexer with internal arbitration.
// Round-robin or fixed-priority grant feeding a one-beat output register.
module bn_stream_mux_rr #(
    parameter int DATA_WIDTH = 2,
    parameter int N_CH       = 3,
    parameter int RR_MODE    = 1,
    parameter int SEL_WIDTH  = $clog2(N_CH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CH-1:0]            in_valid,
    input  logic [N_CH*DATA_WIDTH-1:0] in_data,
    output logic [N_CH-1:0]            in_ready,
    output logic                       out_valid,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [SEL_WIDTH-1:0]       out_sel,
    input  logic                       out_ready
);

    logic [SEL_WIDTH-1:0]  rr_ptr;
    logic [SEL_WIDTH-1:0]  base;
    logic [N_CH-1:0]       grant;
    logic [SEL_WIDTH-1:0]  gidx;
    logic                  found;
    logic                  load;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] ch_data [N_CH];

    for (genvar i = 0; i < N_CH; i++) begin : g_unpack
        assign ch_data[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Output register can take a new beat when empty or being drained.
    assign load = ~out_valid | out_ready;
    assign base = (RR_MODE != 0) ? rr_ptr : '0;

    // Search channels starting at base, wrapping at N_CH-1.
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            int                   idx;
            logic [SEL_WIDTH-1:0] sel;
            idx = int'(base) + k;
            if (idx >= N_CH) idx = idx - N_CH;
            sel = SEL_WIDTH'(idx);
            if (!found && in_valid[sel]) begin
                found      = 1'b1;
                grant[sel] = 1'b1;
                gidx       = sel;
            end
        end
    end

    // Ready only to the granted channel; nothing completes while in reset.
    assign in_ready = grant & {N_CH{load & ~rst}};
    assign xfer     = load & found;

    // Output beat register: load a granted beat or go empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (load) begin
            out_valid <= found;
            if (found) begin
                out_data <= ch_data[gidx];
                out_sel  <= gidx;
            end
        end
    end

    // Round-robin pointer moves just past the channel that transferred.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (RR_MODE != 0 && xfer) begin
            if (gidx == SEL_WIDTH'(N_CH - 1))
                rr_ptr <= '0;
            else
                rr_ptr <= gidx + SEL_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_bn_stream_mux_rr.sv
// Directed bench for bn_stream_mux_rr, one round-robin and one
// fixed-priority instance sharing the same stimulus.
module tb_bn_stream_mux_rr;

    localparam int DW = 2;
    localparam int NC = 3;
    localparam int SW = $clog2(NC);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NC-1:0]  in_valid = '0;
    logic [NC*DW-1:0] in_data = '0;
    logic           out_ready = 1'b0;

    logic [NC-1:0]  rdy0, rdy1;
    logic           ov0, ov1;
    logic [DW-1:0]  od0, od1;
    logic [SW-1:0]  os0, os1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bn_stream_mux_rr #(.DATA_WIDTH(DW), .N_CH(NC), .RR_MODE(1)) u_rr (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy0), .out_valid(ov0), .out_data(od0), .out_sel(os0),
        .out_ready(out_ready)
    );

    bn_stream_mux_rr #(.DATA_WIDTH(DW), .N_CH(NC), .RR_MODE(0)) u_fp (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy1), .out_valid(ov1), .out_data(od1), .out_sel(os1),
        .out_ready(out_ready)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input string tag, input int d, input int s);
        check({tag, "_valid"}, 32'(ov0), 1);
        check({tag, "_data"}, 32'(od0), 32'(d));
        check({tag, "_sel"}, 32'(os0), 32'(s));
    endtask

    initial begin
        // 1. reset with all channels valid
        in_data  = {2'd3, 2'd2, 2'd1};
        in_valid = 3'b111;
        out_ready = 1'b1;
        #12;
        check("rst_valid", 32'(ov0), 0);
        check("rst_data", 32'(od0), 0);
        check("rst_sel", 32'(os0), 0);
        check("rst_ready", 32'(rdy0), 0);
        check("rst_ready_fp", 32'(rdy1), 0);
        check("rst_valid_fp", 32'(ov1), 0);

        // 2. round-robin rotation, full throughput
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rr_ready0", 32'(rdy0), 3'b001);
        tick(); beat("rr1", 1, 0);
        check("rr_ready1", 32'(rdy0), 3'b010);
        tick(); beat("rr2", 2, 1);
        tick(); beat("rr3", 3, 2);
        tick(); beat("rr4", 1, 0);
        check("fp_sel_rr", 32'(os1), 0);

        // 3. backpressure holds the beat, ch1 waits
        out_ready = 1'b0;
        #1;
        check("bp_ready", 32'(rdy0), 0);
        for (int i = 0; i < 4; i++) begin
            tick(); beat("bp_hold", 1, 0);
            check("bp_ready_hold", 32'(rdy0), 0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_rel_ready", 32'(rdy0), 3'b010);
        tick(); beat("bp_next", 2, 1);

        // 4. wrap and skip: ptr=2, only ch0/ch1 valid
        in_valid = 3'b011;
        #1;
        check("wrap_ready", 32'(rdy0), 3'b001);
        tick(); beat("wrap_ch0", 1, 0);
        check("wrap_ready1", 32'(rdy0), 3'b010);
        tick(); beat("wrap_ch1", 2, 1);

        // 5. fixed priority starves ch2 until ch0 drops
        in_valid = 3'b101;
        #1;
        check("fp_ready", 32'(rdy1), 3'b001);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fp_sel", 32'(os1), 0);
            check("fp_data", 32'(od1), 1);
        end
        in_valid = 3'b100;
        #1;
        check("fp_ready2", 32'(rdy1), 3'b100);
        tick();
        check("fp_sel2", 32'(os1), 2);
        check("fp_data2", 32'(od1), 3);

        // 6. async reset between edges
        in_valid = 3'b010;
        tick(); beat("ar_pre", 2, 1);
        #2 rst = 1'b1;
        #1;
        check("ar_valid", 32'(ov0), 0);
        check("ar_ready", 32'(rdy0), 0);
        #1 rst = 1'b0;
        in_valid = 3'b111;
        #1;
        check("ar_ready0", 32'(rdy0), 3'b001);
        tick(); beat("ar_first", 1, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
